// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and types for the instruction fetch stage
package fetch_unit_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT       = 32'h0000_3000;
    localparam logic [INSTR_W-1:0] EXC_ADEL_INSTR_DEFAULT = 32'h0000_0000;

    // Fetch sequencer state encodings
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // One fetched instruction as it travels into IF/ID or the hold buffer
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic               adel;
    } fetch_word_t;

    // Link address of a delay-slot branch; wraps modulo 2^32
    function automatic logic [ADDR_W-1:0] pc_plus8(input logic [ADDR_W-1:0] pc);
        return pc + 32'd8;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - req/ack instruction memory port
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with load, bubble and hold
module ifid_reg
    import fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               bubble,
    input  fetch_word_t        load_word,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc8,
    output logic               adel
);

    // Bubble beats load; with neither asserted the register holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
            pc8   <= '0;
            adel  <= 1'b0;
        end else if (bubble) begin
            valid <= 1'b0;
            instr <= '0;
            adel  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_word.instr;
            pc    <= load_word.pc;
            pc8   <= pc_plus8(load_word.pc);
            adel  <= load_word.adel;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer owning the PC and IF/ID load
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC       = RESET_PC_DEFAULT,
    parameter logic [INSTR_W-1:0] EXC_ADEL_INSTR = EXC_ADEL_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  npc,
    output logic [ADDR_W-1:0]  pc_f,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    fetch_unit_if.master       imem,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [ADDR_W-1:0]  id_pc8,
    output logic               id_exc_adel
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] drain_addr;
    fetch_word_t       hold_word;

    logic        aligned;
    logic        fetch_done;
    logic        outstanding;
    fetch_word_t fetched;
    logic        ifid_load;
    logic        ifid_bubble;
    fetch_word_t ifid_word;

    assign pc_f        = pc;
    assign aligned     = (pc[1:0] == 2'b00);
    // A misaligned PC never reaches memory; it completes at once as a synthetic word
    assign fetch_done  = (state == ST_FETCH) && (!aligned || imem.imem_ack);
    assign outstanding = (state == ST_FETCH) && aligned && !imem.imem_ack;

    // Word produced by a completing fetch, real or synthetic
    always_comb begin
        fetched.instr = aligned ? imem.imem_rdata : EXC_ADEL_INSTR;
        fetched.pc    = pc;
        fetched.adel  = !aligned;
    end

    // Memory request: held until ack, and re-issued to the old address while draining
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc;
        if (rst_n) begin
            case (state)
                ST_FETCH: imem.imem_req = aligned;
                ST_DRAIN: begin
                    imem.imem_req  = 1'b1;
                    imem.imem_addr = drain_addr;
                end
                default: imem.imem_req = 1'b0;
            endcase
        end
    end

    // IF/ID control: redirect flushes, otherwise load on completion or bubble when idle
    always_comb begin
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_word   = fetched;
        if (redirect) begin
            ifid_bubble = 1'b1;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (!stall) begin
                        ifid_load   = fetch_done;
                        ifid_bubble = !fetch_done;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ifid_load = 1'b1;
                        ifid_word = hold_word;
                    end
                end
                default: ifid_bubble = !stall;
            endcase
        end
    end

    // Sequencer: PC advance, hold buffer capture and drain of abandoned requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            drain_addr <= '0;
            hold_word  <= '0;
        end else if (redirect) begin
            pc        <= redirect_pc;
            hold_word <= '0;
            if (state == ST_DRAIN) begin
                state <= imem.imem_ack ? ST_FETCH : ST_DRAIN;
            end else if (outstanding) begin
                drain_addr <= pc;
                state      <= ST_DRAIN;
            end else begin
                state <= ST_FETCH;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    if (fetch_done) begin
                        if (!stall) begin
                            pc <= npc;
                        end else begin
                            hold_word <= fetched;
                            state     <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        pc    <= npc;
                        state <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (imem.imem_ack) begin
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

    ifid_reg u_ifid_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ifid_load),
        .bubble    (ifid_bubble),
        .load_word (ifid_word),
        .valid     (id_valid),
        .instr     (id_instr),
        .pc        (id_pc),
        .pc8       (id_pc8),
        .adel      (id_exc_adel)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit against an instruction-stream model
module tb_fetch_unit;

    localparam logic [31:0] RST_PC   = 32'h0000_3000;
    localparam logic [31:0] ADEL_NOP = 32'h0000_0000;
    localparam int          SEG_LEN  = 800;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc8;
        logic        adel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] npc;
    logic [31:0] pc_f;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic        id_exc_adel;

    fetch_unit_if imem ();

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .npc         (npc),
        .pc_f        (pc_f),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc8      (id_pc8),
        .id_exc_adel (id_exc_adel)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int delivered = 0;

    // Program image: every address holds a distinct word so duplicates or drained data show up
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Next-PC selector: mostly sequential, some taken jumps, some misaligned targets
    function automatic logic [31:0] npc_fn(input logic [31:0] p);
        logic [31:0] base;
        base = {p[31:2], 2'b00};
        if (p[1:0] != 2'b00)      return base + 32'd8;
        else if (p[5:2] == 4'hd)  return p + 32'd6;
        else if (p[5:2] == 4'h7)  return p + 32'h40;
        else                      return p + 32'd4;
    endfunction

    assign npc = npc_fn(pc_f);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_id_valid"}, {31'd0, id_valid}, 32'd0);
        check({tag, "_id_instr"}, id_instr, 32'd0);
        check({tag, "_id_pc"}, id_pc, 32'd0);
        check({tag, "_id_pc8"}, id_pc8, 32'd0);
        check({tag, "_id_adel"}, {31'd0, id_exc_adel}, 32'd0);
        check({tag, "_pc_f"}, pc_f, RST_PC);
        check({tag, "_req"}, {31'd0, imem.imem_req}, 32'd0);
    endtask

    // Monitor: expected instruction stream, regenerated from the target after any redirect/reset
    exp_t        q[$];
    logic [31:0] exp_next = RST_PC;
    exp_t        last;
    logic        pv = 1'b0, ps = 1'b0, pr = 1'b0;
    int          idle = 0;

    task automatic gen_expected();
        exp_t e;
        e.pc    = exp_next;
        e.adel  = (exp_next[1:0] != 2'b00);
        e.instr = e.adel ? ADEL_NOP : mem_fn(exp_next);
        e.pc8   = exp_next + 32'd8;
        q.push_back(e);
        exp_next = npc_fn(exp_next);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                exp_next = RST_PC;
                pv = 1'b0; ps = 1'b0; pr = 1'b0;
                idle = 0;
            end else begin
                if (pr) begin
                    check("bubble_after_redirect", {31'd0, id_valid}, 32'd0);
                end else if (id_valid) begin
                    if (pv && ps) begin
                        check("held_instr", id_instr, last.instr);
                        check("held_pc", id_pc, last.pc);
                        check("held_adel", {31'd0, id_exc_adel}, {31'd0, last.adel});
                    end else begin
                        if (q.size() == 0) gen_expected();
                        e = q.pop_front();
                        check("id_pc", id_pc, e.pc);
                        check("id_instr", id_instr, e.instr);
                        check("id_pc8", id_pc8, e.pc8);
                        check("id_adel", {31'd0, id_exc_adel}, {31'd0, e.adel});
                        last = e;
                        delivered++;
                        idle = 0;
                    end
                end
                idle++;
                if (idle > 100) begin
                    check("progress_timeout", 32'd0, 32'd1);
                    idle = 0;
                end
                if (redirect) begin
                    q.delete();
                    exp_next = redirect_pc;
                end
                pv = id_valid; ps = stall; pr = redirect;
            end
        end
    end

    // Driver: stall/redirect stimulus plus a variable-latency memory
    int          lat = 0;
    logic        prev_req = 1'b0, prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;
    int          full_cnt = 0;
    int          stall_pct, redir_pct, max_lat;
    logic        did_reset;

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        imem.imem_ack = 1'b0;
        imem.imem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 check_reset("init");
        #2 rst_n = 1'b1;
        #1 check("first_addr", imem.imem_addr, RST_PC);

        for (int seg = 0; seg < 4; seg++) begin
            case (seg)
                0: begin stall_pct = 0;  redir_pct = 0; max_lat = 0; end
                1: begin stall_pct = 30; redir_pct = 0; max_lat = 3; end
                2: begin stall_pct = 25; redir_pct = 6; max_lat = 3; end
                default: begin stall_pct = 45; redir_pct = 4; max_lat = 2; end
            endcase
            did_reset = 1'b0;
            for (int cyc = 0; cyc < SEG_LEN; cyc++) begin
                @(posedge clk);
                #1;
                if (seg == 0 && cyc >= 4 && id_valid) full_cnt++;

                if (prev_req && !prev_ack) begin
                    check("req_held", {31'd0, imem.imem_req}, 32'd1);
                    check("addr_held", imem.imem_addr, prev_addr);
                end

                stall    = ($urandom_range(0, 99) < stall_pct);
                redirect = ($urandom_range(0, 99) < redir_pct);
                case ($urandom_range(0, 7))
                    0:       redirect_pc = 32'hFFFF_FFF8;
                    1:       redirect_pc = {16'h0000, $urandom_range(0, 65535)} | 32'd1;
                    default: redirect_pc = {16'h0000, $urandom_range(0, 16383), 2'b00};
                endcase

                imem.imem_ack   = 1'b0;
                imem.imem_rdata = $urandom;
                if (imem.imem_req) begin
                    if (lat == 0) begin
                        imem.imem_ack   = 1'b1;
                        imem.imem_rdata = mem_fn(imem.imem_addr);
                        lat = $urandom_range(0, max_lat);
                    end else begin
                        lat--;
                    end
                end
                prev_req  = imem.imem_req;
                prev_ack  = imem.imem_ack;
                prev_addr = imem.imem_addr;

                // Seg 2: reset during a waiting request; seg 3: reset while holding a word
                if (!did_reset && cyc >= 300 &&
                    ((seg == 2 && imem.imem_req && !imem.imem_ack) ||
                     (seg == 3 && !imem.imem_req && stall && pc_f[1:0] == 2'b00))) begin
                    did_reset = 1'b1;
                    #2 rst_n = 1'b0;
                    #1 check_reset("midrst");
                    stall = 1'b0;
                    redirect = 1'b0;
                    imem.imem_ack = 1'b0;
                    lat = 0;
                    prev_req = 1'b0;
                    prev_ack = 1'b0;
                    @(posedge clk);
                    #3 rst_n = 1'b1;
                    #1 check("post_rst_addr", imem.imem_addr, RST_PC);
                    check("post_rst_req", {31'd0, imem.imem_req}, 32'd1);
                end
            end
        end

        check("zero_latency_full_rate", full_cnt, SEG_LEN - 4);
        check("min_delivered", {31'd0, (delivered >= 1500)}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sequencer. Owns the architectural PC and issues requests on a req/ack instruction-memory port.
- Consumes the combinational next-PC (npc) that the IF next-PC selector computes from pc_f. Loads the IF/ID pipeline register.
- Handles ID-stage stalls, exception/eret redirects, misaligned fetch, and variable-latency memory, so that a fetched instruction is never lost or duplicated.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.
EXC_ADEL_INSTR, 32'h0000_0000, instruction word (nop) injected when the fetch address is misaligned.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
npc  in  32  next PC from the next-PC selector, valid in the cycle a fetch commits
pc_f  out  32  current fetch PC, fed to the next-PC selector
stall  in  1  ID stage holding; IF/ID must not change
redirect  in  1  exception/eret redirect; highest priority
redirect_pc  in  32  redirect target
imem_req  out  1  fetch request
imem_addr  out  32  fetch byte address
imem_ack  in  1  data valid this cycle (same cycle as req allowed)
imem_rdata  in  32  instruction word
id_valid  out  1  IF/ID holds a real instruction
id_instr  out  32  IF/ID instruction
id_pc  out  32  IF/ID PC
id_pc8  out  32  id_pc+8, link address (delay slot)
id_exc_adel  out  1  IF/ID instruction came from a misaligned fetch

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH.
  - id_valid=0, id_instr=0, id_pc=0, id_pc8=0, id_exc_adel=0.
  - hold buffer cleared.
  - imem_req forced 0 while rst_n=0.
  - Reset mid-request abandons it; the memory is reset by the same rst_n.
- States: FETCH, HOLD, DRAIN.
- FETCH:
  - If pc[1:0]==0: imem_req=1, imem_addr=pc.
  - If pc[1:0]!=0: imem_req=0, and the fetch completes immediately as a "synthetic" instruction EXC_ADEL_INSTR with adel=1.
- Request rule: once imem_req=1 with address A, the request stays asserted with A until imem_ack. It is never withdrawn.
- Fetch completes (ack, or synthetic):
  - stall=0: IF/ID <= {1, instr, pc, pc+8, adel}; pc <= npc; stay FETCH. This gives 1 instr/cycle with zero-latency memory.
  - stall=1: buffer {instr, pc, adel}; pc holds; go HOLD.
- FETCH without completion:
  - stall=0: IF/ID <= bubble (valid=0, instr=0, adel=0; id_pc unchanged).
  - stall=1: IF/ID holds.
- HOLD:
  - imem_req=0.
  - stall=0: IF/ID <= buffer with valid=1; pc <= npc; go FETCH.
  - stall=1: remain in HOLD.
- Redirect, in any state, overrides all of the above:
  - pc <= redirect_pc; IF/ID <= bubble, even if stall=1; hold buffer discarded.
  - If a request is outstanding (FETCH, req=1, no ack this cycle): latch drain_addr=imem_addr and go DRAIN. Otherwise go FETCH.
- DRAIN:
  - imem_req=1, imem_addr=drain_addr.
  - On ack, discard the data and go FETCH.
  - pc_f = redirect target throughout.
  - A further redirect in DRAIN updates pc only.
- pc_f = pc register at all times.
- id_pc8 = id_pc + 32'd8, registered, with wrap-around modulo 2^32. pc+4 and pc+8 also wrap at 32'hFFFF_FFFC.
- Simultaneous ack and redirect: redirect wins and the acked data is discarded. No DRAIN is needed because the request is complete.

Decomposition:
- Shared CPU constants/defines file holds:
  - RESET_PC default
  - state encodings FETCH/HOLD/DRAIN (2-bit)
  - the IF/ID bundle field widths
- One natural sub-module, ifid_reg: the IF/ID pipeline register with load/bubble/hold controls and async active-low reset.
- FSM, PC, and hold buffer stay in fetch_unit.

Test Plan:
1. Zero-latency memory (ack=req), no stall, npc=pc_f+4 → after reset, id_pc = 0x3000, 0x3004, 0x3008 on consecutive cycles; id_pc8=0x3008 with id_pc=0x3000; id_valid=1 every cycle.
2. 3-cycle ack latency → imem_addr=0x3000 held stable 3 cycles; bubble (id_valid=0) during the wait; then id_instr=rdata, id_pc=0x3000.
3. Ack with stall=1 for 4 cycles → pc_f stays 0x3004, imem_req=0 in HOLD, IF/ID unchanged; on stall release id_instr equals the buffered word, pc_f=npc.
4. Redirect to 0x4180 while a request for 0x3010 is outstanding → id_valid=0 next cycle; imem_addr stays 0x3010 until ack; that data is never loaded; next request is 0x4180.
5. npc=0x3002 → no imem_req; next IF/ID has id_exc_adel=1, id_instr=0, id_pc=0x3002.
6. rst_n pulsed low mid-wait and mid-HOLD → outputs zero immediately, pc_f=0x3000, imem_req=0; first post-reset fetch is 0x3000.
